// File: rtl/ff_pkg.sv
// Shared mode encodings and the per-channel next-state function for the configurable flip-flop bank.
package ff_pkg;

    localparam int unsigned MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_D  = 2'b00;
    localparam mode_t MODE_T  = 2'b01;
    localparam mode_t MODE_JK = 2'b10;
    localparam mode_t MODE_SR = 2'b11;

    typedef struct packed {
        logic q;
        logic sr_illegal;
    } ff_next_t;

    // Next stored bit for one channel; sr_illegal flags S=R=1 in SR mode.
    function automatic ff_next_t next_state(mode_t mode, logic q, logic a, logic b);
        ff_next_t r;
        r.q          = q;
        r.sr_illegal = 1'b0;
        case (mode)
            MODE_D:  r.q = a;
            MODE_T:  r.q = q ^ a;
            MODE_JK: begin
                case ({a, b})
                    2'b00:   r.q = q;
                    2'b01:   r.q = 1'b0;
                    2'b10:   r.q = 1'b1;
                    default: r.q = ~q;
                endcase
            end
            default: begin
                case ({a, b})
                    2'b00:   r.q = q;
                    2'b01:   r.q = 1'b0;
                    2'b10:   r.q = 1'b1;
                    default: begin
                        r.q          = q;
                        r.sr_illegal = 1'b1;
                    end
                endcase
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ff_cell.sv
// One channel of the bank: a mode register and a stored bit, updated together on each enabled edge.
module ff_cell
    import ff_pkg::*;
#(
    parameter mode_t RESET_MODE = MODE_D
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  logic  a,
    input  logic  b,
    input  logic  mode_we,
    input  mode_t mode_wdata,
    output logic  q,
    output logic  q_next_c,
    output logic  err_pulse_c
);

    mode_t    mode_q, mode_d;
    logic     q_q, q_d;
    ff_next_t nxt;

    // The same-edge update always sees the mode held before this edge.
    always_comb begin
        nxt         = next_state(mode_q, q_q, a, b);
        q_d         = q_q;
        mode_d      = mode_q;
        err_pulse_c = 1'b0;
        if (en) begin
            q_d         = nxt.q;
            err_pulse_c = nxt.sr_illegal;
        end
        if (mode_we) begin
            mode_d = mode_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= RESET_MODE;
            q_q    <= 1'b0;
        end else begin
            mode_q <= mode_d;
            q_q    <= q_d;
        end
    end

    assign q        = q_q;
    assign q_next_c = q_d;

endmodule

// File: rtl/ff_bank_mux.sv
// Bank of run-time configurable D/T/JK/SR flip-flops with a registered tap mux and a sticky SR-illegal flag.
module ff_bank_mux
    import ff_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned SEL_W      = $clog2(CHANNELS),
    parameter mode_t       RESET_MODE = MODE_D
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [CHANNELS-1:0] a,
    input  logic [CHANNELS-1:0] b,
    input  logic                cfg_we,
    input  logic [SEL_W-1:0]    cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic                clr_err,
    output logic [CHANNELS-1:0] q,
    output logic                T,
    output logic                err
);

    localparam bit INDEX_FULL = ((1 << SEL_W) == CHANNELS);

    logic [CHANNELS-1:0] q_next;
    logic [CHANNELS-1:0] err_pulse;
    logic                cfg_ok;
    logic                sel_ok;
    logic                tap_q, tap_d;
    logic                err_q, err_d;

    // Out-of-range indices can only occur when CHANNELS is not a power of two.
    generate
        if (INDEX_FULL) begin : g_full_idx
            assign cfg_ok = 1'b1;
            assign sel_ok = 1'b1;
        end else begin : g_part_idx
            assign cfg_ok = (32'(cfg_ch) < CHANNELS);
            assign sel_ok = (32'(sel) < CHANNELS);
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic mode_we;
            assign mode_we = cfg_we & cfg_ok & (cfg_ch == SEL_W'(i));

            ff_cell #(
                .RESET_MODE (RESET_MODE)
            ) u_cell (
                .clk         (clk),
                .reset       (reset),
                .en          (en),
                .a           (a[i]),
                .b           (b[i]),
                .mode_we     (mode_we),
                .mode_wdata  (mode_t'(cfg_mode)),
                .q           (q[i]),
                .q_next_c    (q_next[i]),
                .err_pulse_c (err_pulse[i])
            );
        end
    endgenerate

    // Tap follows the post-edge state; a new set of err pulses beats a same-edge clear.
    always_comb begin
        tap_d = 1'b0;
        err_d = err_q;
        if (sel_ok) begin
            tap_d = q_next[sel];
        end
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (|err_pulse) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tap_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            tap_q <= tap_d;
            err_q <= err_d;
        end
    end

    assign T   = tap_q;
    assign err = err_q;

endmodule

// File: tb/tb_ff_bank_mux.sv
// Directed self-checking bench for ff_bank_mux with CHANNELS=4.
module tb_ff_bank_mux;

    localparam int unsigned CH = 4;
    localparam int unsigned SW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [CH-1:0] a;
    logic [CH-1:0] b;
    logic          cfg_we;
    logic [SW-1:0] cfg_ch;
    logic [1:0]    cfg_mode;
    logic [SW-1:0] sel;
    logic          clr_err;
    logic [CH-1:0] q;
    logic          T;
    logic          err;

    int total = 0;
    int bad   = 0;

    ff_bank_mux #(.CHANNELS(CH), .SEL_W(SW), .RESET_MODE(2'b00)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .a        (a),
        .b        (b),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mode (cfg_mode),
        .sel      (sel),
        .clr_err  (clr_err),
        .q        (q),
        .T        (T),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mode(input logic [SW-1:0] ch, input logic [1:0] m);
        en       = 1'b0;
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_mode = m;
        step();
        cfg_we   = 1'b0;
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; a = 4'hF; b = 4'h0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_mode = 2'b00; sel = '0; clr_err = 1'b0;

        // 1. reset state and default D mode
        step(); step();
        check("rst_q", 32'(q), 32'h0);
        check("rst_T", 32'(T), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        reset = 1'b1; en = 1'b1; a = 4'b1010; sel = 2'd1;
        step();
        check("d_load_q", 32'(q), 32'hA);
        check("d_load_T", 32'(T), 32'h1);

        // 2. ch2 -> T mode; same edge still uses D
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'b01; a = 4'b0100;
        step();
        cfg_we = 1'b0;
        check("cfg_same_edge_q", 32'(q), 32'h4);
        check("cfg_same_edge_T", 32'(T), 32'h0);
        step();
        check("t_toggle0", 32'(q), 32'h0);
        step();
        check("t_toggle1", 32'(q), 32'h4);

        // 3. ch0 JK truth table; ch2 holds via a[2]=0
        write_mode(2'd0, 2'b10);
        check("cfg_hold_q", 32'(q), 32'h4);
        en = 1'b1; sel = 2'd0;
        a = 4'b0000; b = 4'b0000; step();
        check("jk_00", 32'(q), 32'h4);
        a = 4'b0001; b = 4'b0000; step();
        check("jk_10", 32'(q), 32'h5);
        check("jk_tap", 32'(T), 32'h1);
        a = 4'b0001; b = 4'b0001; step();
        check("jk_11a", 32'(q), 32'h4);
        step();
        check("jk_11b", 32'(q), 32'h5);
        a = 4'b0000; b = 4'b0001; step();
        check("jk_01", 32'(q), 32'h4);

        // 4. ch3 SR: set, illegal, sticky, clear
        write_mode(2'd3, 2'b11);
        en = 1'b1; a = 4'b1000; b = 4'b0000; step();
        check("sr_set_q", 32'(q), 32'hC);
        check("sr_set_err", 32'(err), 32'h0);
        a = 4'b1000; b = 4'b1000; step();
        check("sr_ill_q", 32'(q), 32'hC);
        check("sr_ill_err", 32'(err), 32'h1);
        a = 4'b0000; b = 4'b0000; step();
        check("err_sticky", 32'(err), 32'h1);
        a = 4'b1000; b = 4'b1000; clr_err = 1'b1; step();
        check("err_set_wins", 32'(err), 32'h1);
        a = 4'b0000; b = 4'b0000; step();
        check("err_clear", 32'(err), 32'h0);
        check("sr_hold_q", 32'(q), 32'hC);
        clr_err = 1'b0;

        // 5. en=0 hold with random inputs, then tap sweep
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            a = 4'($urandom); b = 4'($urandom);
            if (k == 0) begin
                a = 4'hF; b = 4'hF;
            end
            step();
            check("en0_hold_q", 32'(q), 32'hC);
            check("en0_no_err", 32'(err), 32'h0);
        end
        for (int s = 0; s < 4; s++) begin
            logic [CH-1:0] ref_q;
            ref_q = 4'hC;
            sel = SW'(s);
            step();
            check("tap_sweep", 32'(T), 32'(ref_q[s]));
        end

        // 6. async reset mid-cycle with a pending mode write
        en = 1'b1; a = 4'b1000; b = 4'b1000; sel = 2'd3; step();
        check("pre_rst_err", 32'(err), 32'h1);
        check("pre_rst_T", 32'(T), 32'h1);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'b11; a = 4'hF; b = 4'h0;
        #2;
        reset = 1'b0;
        #1;
        check("async_q", 32'(q), 32'h0);
        check("async_T", 32'(T), 32'h0);
        check("async_err", 32'(err), 32'h0);
        step();
        check("rst_held_q", 32'(q), 32'h0);
        reset = 1'b1; cfg_we = 1'b0; en = 1'b1; a = 4'b1011; b = 4'b1011;
        step();
        check("post_rst_all_d_q", 32'(q), 32'hB);
        check("post_rst_no_err", 32'(err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ff_bank_mux.md
Name: ff_bank_mux

Overview:
- Parametrised array of CHANNELS single-bit storage elements.
- Each channel is run-time configurable as D, T, JK or SR flip-flop.
- A registered tap mux selects one channel onto output T.
- Generalises the fixed D/T/JK trio plus 4:1 select into one configurable, scalable block for the lab datapath.

Parameters:
- CHANNELS, 4: number of flip-flop channels (2..32).
- SEL_W, $clog2(CHANNELS): width of sel and cfg_ch.
- RESET_MODE, 2'b00: mode loaded into every channel on reset (00 = D).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  global update enable; when 0, all channel states hold.
- a  input  CHANNELS  per-channel primary input (D / T / J / S).
- b  input  CHANNELS  per-channel secondary input (K / R); ignored in D and T modes.
- cfg_we  input  1  mode-register write strobe.
- cfg_ch  input  SEL_W  channel index for the mode write.
- cfg_mode  input  2  mode value: 00 D, 01 T, 10 JK, 11 SR.
- sel  input  SEL_W  tap select for T.
- clr_err  input  1  clears the sticky err flag.
- q  output  CHANNELS  current state of all channels.
- T  output  1  registered copy of q[sel].
- err  output  1  sticky flag: an SR channel saw S=R=1 while en=1.

Behaviour:
- Reset (reset=0, asynchronous), outputs and state take these values:
  - q = 0, T = 0, err = 0.
  - every mode[i] = RESET_MODE.
  - Deassertion is synchronous to clk in the surrounding design. The block applies no sync stage.
- Reset asserted mid-operation overrides everything in the same instant, including a pending cfg_we.
- Channel update, per rising edge when en=1, using the mode held before this edge:
  - D: q[i] <= a[i].
  - T: q[i] <= q[i] ^ a[i].
  - JK:
    - 00 hold.
    - 01 clear.
    - 10 set.
    - 11 toggle.
  - SR:
    - 00 hold.
    - 01 clear.
    - 10 set.
    - 11 hold q[i] and set err.
- en=0: q holds in all modes. No err is generated.
- Mode write, on rising edge with cfg_we=1 and cfg_ch < CHANNELS:
  - mode[cfg_ch] <= cfg_mode.
  - The new mode first affects the update on the following edge.
  - The same-edge update uses the old mode.
- cfg_ch >= CHANNELS: the write is ignored and no state changes.
- Mode change does not alter q. The stored bit carries over into the new mode.
- Tap output:
  - T <= q_next[sel] each edge, so T equals q[sel] as of the same edge.
  - Latency: 1 clock from a/b/sel to T.
  - sel >= CHANNELS: T <= 0.
- err:
  - Set on any edge where any SR-mode channel has en=1, a[i]=1 and b[i]=1.
  - Cleared by clr_err=1.
  - If set and clear occur on the same edge, set wins.
  - err stays asserted until cleared or reset.
- All channels update in parallel. There is no inter-channel dependency.

Decomposition:
- Shared package ff_pkg:
  - mode typedef/constants MODE_D=2'b00, MODE_T=2'b01, MODE_JK=2'b10, MODE_SR=2'b11.
  - a function next_state(mode, q, a, b) returning the next bit, plus an sr_illegal indication.
- One natural sub-module, ff_cell: one channel holding its mode register and q bit, with an err_pulse output.
- ff_bank_mux instantiates CHANNELS ff_cell instances via generate, then adds the tap register and the sticky err register.

Test Plan (CHANNELS=4):
1. Reset and default mode:
   - Stimulus: reset=0 with a=4'hF, then release; en=1, a=4'b1010.
   - Response: during reset q=0, T=0, err=0. After one edge q=4'b1010. With sel=1, T=1 on that same edge.
2. Mode reconfiguration and timing:
   - Stimulus: write ch2 to T mode while en=1, a=4'b0100 on the same edge.
   - Response: ch2 loads 1 as a D flip-flop. On the next edges with a[2]=1, q[2] toggles 1→0→1.
3. JK full truth table:
   - Stimulus: ch0 in JK; drive J/K = 00, 10, 11, 11, 01 on successive edges.
   - Response: q[0] = 0, 1, 0, 1, 0.
4. SR illegal input:
   - Stimulus: ch3 in SR with q[3]=1; drive a[3]=b[3]=1.
   - Response: q[3] stays 1 and err=1.
   - Follow-up: apply clr_err with S=R=1 still driven, then with S=R=0. err remains 1 on the first edge and clears to 0 on the second.
5. Enable hold and tap select:
   - Stimulus: set en=0 with random a/b for 5 cycles.
   - Response: q is unchanged. Sweeping sel 0..3 gives T = the corresponding q bit after 1 clock.
6. Asynchronous reset mid-run:
   - Stimulus: assert reset between clock edges while cfg_we=1.
   - Response: q, T and err go to 0 immediately. All modes become D, and the write does not take effect.
